// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH / MDU_CNT_W : default operand width and iteration counter width
//   OP_*                  : operation encodings carried on the op bus
//   state_t               : controller state encoding
//   op_is_div/op_is_signed: decode helpers for the op field
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 16;
    localparam int MDU_CNT_W = 5;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the regfile-side issuer and the
// multiply/divide unit.
//   start, op, a_in, b_in      : request side (driven by master)
//   busy, done, div_by_zero,
//   hi, lo                     : status and results (driven by slave)
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_sign_mag.sv
// sign_mag: conditional two's-complement negation.
//   x      in  W  value to condition
//   neg_en in  1  negate x when set (abs of a negative operand, or sign fix-up)
//   mag    out W  neg_en ? -x : x
// The most negative value maps to itself, which read as unsigned is its true
// magnitude, so a W-bit unsigned result is enough for operand conditioning.
module sign_mag #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic         neg_en,
    output logic [W-1:0] mag
);
    assign mag = neg_en ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative WIDTH-bit multiply/divide, one shift-add or restoring
// step per cycle.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport: start/op/a_in/b_in request; busy/done/div_by_zero/hi/lo
//
// state     | meaning
// ST_IDLE   | waiting for start; done pulses here for one cycle after a result
// ST_RUN    | WIDTH unsigned iterations on operand magnitudes
// ST_FINISH | sign fix-up, hi/lo/done registered on leaving
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_q;
    logic               sa_q, sb_q, dz_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   mcand_q;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;          // mul: {partial sum, multiplier}; div: low half shifts dividend in, quotient out
    logic [WIDTH-1:0]   rem;

    logic               busy_q, done_q, dz_out_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               sa_in, sb_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    logic [WIDTH:0]     mul_upper;
    logic [WIDTH:0]     trial, diff;
    logic               fits;

    assign sa_in = op_is_signed(bus.op) & bus.a_in[WIDTH-1];
    assign sb_in = op_is_signed(bus.op) & bus.b_in[WIDTH-1];

    sign_mag #(.W(WIDTH))   u_a_mag (.x(bus.a_in),         .neg_en(sa_in),       .mag(a_mag));
    sign_mag #(.W(WIDTH))   u_b_mag (.x(bus.b_in),         .neg_en(sb_in),       .mag(b_mag));
    sign_mag #(.W(2*WIDTH)) u_prod  (.x(acc),              .neg_en(sa_q ^ sb_q), .mag(prod_res));
    sign_mag #(.W(WIDTH))   u_quo   (.x(acc[WIDTH-1:0]),   .neg_en(sa_q ^ sb_q), .mag(quo_res));
    sign_mag #(.W(WIDTH))   u_rem   (.x(rem),              .neg_en(sa_q),        .mag(rem_res));

    always_comb begin
        mul_upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
        trial     = {rem, acc[WIDTH-1]};
        diff      = trial - {1'b0, mcand_q};
        // trial < 2*divisor, so the wrapped difference has its top bit set exactly when it went negative
        fits      = ~diff[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            a_raw_q  <= '0;
            mcand_q  <= '0;
            acc      <= '0;
            rem      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        is_div_q <= op_is_div(bus.op);
                        sa_q     <= sa_in;
                        sb_q     <= sb_in;
                        a_raw_q  <= bus.a_in;
                        mcand_q  <= op_is_div(bus.op) ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? a_mag : b_mag)};
                        rem      <= '0;
                        cnt      <= '0;
                        dz_out_q <= 1'b0;
                        busy_q   <= 1'b1;
                        dz_q     <= op_is_div(bus.op) && (bus.b_in == '0);
                        if (op_is_div(bus.op) && (bus.b_in == '0))
                            state <= ST_FINISH;
                        else
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (is_div_q) begin
                        rem            <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], fits};
                    end else begin
                        acc <= {mul_upper, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= ST_FINISH;
                end
                ST_FINISH: begin
                    if (dz_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= rem_res;
                        lo_q <= quo_res;
                    end else begin
                        hi_q <= prod_res[2*WIDTH-1:WIDTH];
                        lo_q <= prod_res[WIDTH-1:0];
                    end
                    dz_out_q <= dz_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_out_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mul_div_unit_if #(.WIDTH(W)) bus();

    mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {div_by_zero, hi, lo}
    function automatic logic [32:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        longint p;
        int     q, r, sa, sb;
        logic [63:0] pv;
        logic [31:0] qv, rv;
        if (op == OP_MULTU || op == OP_MULT) begin
            if (op == OP_MULTU) p = longint'(a) * longint'(b);
            else                p = longint'($signed(a)) * longint'($signed(b));
            pv = p;
            return {1'b0, pv[31:0]};
        end
        if (b == 16'h0000) return {1'b1, a, 16'hFFFF};
        if (op == OP_DIVU) begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
        end
        qv = q;
        rv = r;
        return {1'b0, rv[15:0], qv[15:0]};
    endfunction

    // Cycle-level expectation: an accepted op yields its result LAT edges later
    // (one edge for divide by zero); results hold until the next completion.
    logic [32:0] pend = '0;
    int          m_left = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [15:0] m_hi = '0, m_lo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_dz, m_hi, m_lo} = pend;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (bus.start) begin
                pend   = ref_op(bus.op, bus.a_in, bus.b_in);
                m_left = pend[32] ? 1 : LAT;
                m_busy = 1'b1;
                m_dz   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_busy", 33'(bus.busy), 33'(m_busy));
            chk("mon_done", 33'(bus.done), 33'(m_done));
            chk("mon_dz",   33'(bus.div_by_zero), 33'(m_dz));
            chk("mon_hi",   33'(bus.hi), 33'(m_hi));
            chk("mon_lo",   33'(bus.lo), 33'(m_lo));
        end
    end

    // Called at posedge+1; drives a request that the next edge accepts.
    task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] hi_e, input logic [15:0] lo_e, input logic dz_e,
                          input int lat_e, input bit hold);
        int n;
        n = 0;
        bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
        @(posedge clk); #1;
        bus.start = hold;
        while (!bus.done && n < 40) begin
            if (hold) begin
                bus.a_in = 16'($urandom);
                bus.b_in = 16'($urandom);
                bus.op   = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            chk({name, "_timeout"}, 33'(n), 33'(0));
        end else begin
            chk({name, "_lat"}, 33'(n), 33'(lat_e));
            chk({name, "_hi"},  33'(bus.hi), 33'(hi_e));
            chk({name, "_lo"},  33'(bus.lo), 33'(lo_e));
            chk({name, "_dz"},  33'(bus.div_by_zero), 33'(dz_e));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  rop;
        int          n;

        bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;

        chk("ref_multu", ref_op(OP_MULTU, 16'hFFFF, 16'hFFFF), {1'b0, 16'hFFFE, 16'h0001});
        chk("ref_mult",  ref_op(OP_MULT,  16'hFFFD, 16'h0007), {1'b0, 16'hFFFF, 16'hFFEB});
        chk("ref_div",   ref_op(OP_DIV,   16'hFFF9, 16'h0002), {1'b0, 16'hFFFF, 16'hFFFD});
        chk("ref_divov", ref_op(OP_DIV,   16'h8000, 16'hFFFF), {1'b0, 16'h0000, 16'h8000});
        chk("ref_dz",    ref_op(OP_DIVU,  16'h1234, 16'h0000), {1'b1, 16'h1234, 16'hFFFF});

        #3;
        chk("rst_busy", 33'(bus.busy), 33'(0));
        chk("rst_done", 33'(bus.done), 33'(0));
        chk("rst_hi",   33'(bus.hi),   33'(0));
        chk("rst_lo",   33'(bus.lo),   33'(0));
        chk("rst_dz",   33'(bus.div_by_zero), 33'(0));
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu_ffff", OP_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, LAT, 1'b0);
        run_op("mult_neg",   OP_MULT,  16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0, LAT, 1'b0);
        run_op("mult_min",   OP_MULT,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, LAT, 1'b0);
        run_op("divu_100_7", OP_DIVU,  16'd100,  16'd7,    16'd2,    16'd14,   1'b0, LAT, 1'b0);
        run_op("div_neg",    OP_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, LAT, 1'b0);
        run_op("div_ovf",    OP_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, LAT, 1'b0);
        run_op("div_negb",   OP_DIV,   16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, LAT, 1'b0);
        run_op("divu_zero",  OP_DIVU,  16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1,   1'b0);
        run_op("dz_clear",   OP_DIVU,  16'd100,  16'd7,    16'd2,    16'd14,   1'b0, LAT, 1'b0);
        run_op("hold_start", OP_MULTU, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, LAT, 1'b1);

        // abort mid-operation with reset
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a_in = 16'hBEEF; bus.b_in = 16'h0013;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 33'(bus.busy), 33'(0));
        chk("abort_done", 33'(bus.done), 33'(0));
        chk("abort_hi",   33'(bus.hi),   33'(0));
        chk("abort_lo",   33'(bus.lo),   33'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", OP_MULT, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, LAT, 1'b0);

        // random traffic; start/operands are scrambled while busy and must be ignored
        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: ra = 16'h8000;
                default: ;
            endcase
            bus.start = 1'b1; bus.op = rop; bus.a_in = ra; bus.b_in = rb;
            @(posedge clk); #1;
            n = 0;
            while (!bus.done && n < 40) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.a_in  = 16'($urandom);
                bus.b_in  = 16'($urandom);
                @(posedge clk); #1;
                n++;
            end
            bus.start = 1'b0;
            if (!bus.done) chk("rand_timeout", 33'(n), 33'(0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
